// File: rtl/global_int_gateway.sv
// Receive side of the global-interrupt bus: per-line synchronizer, trigger
// detection and IDLE/PENDING/INFLIGHT gateway, plus a claim/complete port.
module global_int_gateway #(
    parameter int NUM_INT     = 64,
    parameter int ID_W        = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_INT-1:0]   int_in,
    input  logic [NUM_INT-1:0]   int_edge_mode,
    input  logic [NUM_INT-1:0]   int_enable,
    input  logic                 claim_req,
    output logic                 claim_valid,
    output logic [ID_W-1:0]      claim_id,
    input  logic                 complete_valid,
    input  logic [ID_W-1:0]      complete_id,
    output logic                 irq_out,
    output logic [NUM_INT-1:0]   pending_out,
    output logic                 err_complete,
    output logic [2*NUM_INT-1:0] dbg_line_state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_INFLIGHT = 2'd2
    } line_state_e;

    // Handshake: claim_req and complete_valid are single-cycle samples on the
    // rising edge; claim_valid/err_complete are one-cycle responses the next cycle.

    logic [NUM_INT-1:0] sync_q [SYNC_STAGES];
    logic [NUM_INT-1:0] prev_q;
    logic [NUM_INT-1:0] s_vec;
    logic [NUM_INT-1:0] trig;

    line_state_e        state_q [NUM_INT];
    line_state_e        state_d [NUM_INT];
    logic [NUM_INT-1:0] latch_q;
    logic [NUM_INT-1:0] latch_d;

    logic [NUM_INT-1:0] pend_vec;
    logic [NUM_INT-1:0] grant;
    logic [NUM_INT-1:0] legal;
    logic [ID_W-1:0]    sel_id;
    logic               sel_found;
    logic               complete_err;

    logic               claim_valid_q;
    logic [ID_W-1:0]    claim_id_q;
    logic               irq_q;
    logic               err_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= int_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_q <= s_vec;
        end
    end

    assign s_vec = sync_q[SYNC_STAGES-1];
    assign trig  = (s_vec & ~prev_q & int_edge_mode) | (s_vec & ~int_edge_mode);

    // Arbitration sees only the pre-edge state, so a line completing this
    // cycle cannot be claimed until the next one.
    always_comb begin
        pend_vec  = '0;
        grant     = '0;
        sel_id    = '0;
        sel_found = 1'b0;
        for (int i = 0; i < NUM_INT; i++) begin
            pend_vec[i] = (state_q[i] == ST_PENDING);
            if (!sel_found && pend_vec[i] && int_enable[i]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(i + 1);
                grant[i]  = claim_req;
            end
        end
    end

    always_comb begin
        legal = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            legal[i] = complete_valid && (complete_id == ID_W'(i + 1)) &&
                       (state_q[i] == ST_INFLIGHT);
        end
        complete_err = complete_valid && (legal == '0);
    end

    always_comb begin
        latch_d = latch_q;
        for (int i = 0; i < NUM_INT; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (trig[i]) state_d[i] = ST_PENDING;
                end
                ST_PENDING: begin
                    if (int_edge_mode[i] && trig[i]) latch_d[i] = 1'b1;
                    if (grant[i]) state_d[i] = ST_INFLIGHT;
                end
                ST_INFLIGHT: begin
                    if (int_edge_mode[i] && trig[i]) latch_d[i] = 1'b1;
                    // An edge arriving on the completion edge counts as latched.
                    if (legal[i]) begin
                        latch_d[i] = 1'b0;
                        if (int_edge_mode[i] && (latch_q[i] || trig[i])) begin
                            state_d[i] = ST_PENDING;
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    latch_d[i] = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_INT; i++) begin
                state_q[i] <= ST_IDLE;
            end
            latch_q       <= '0;
            claim_valid_q <= 1'b0;
            claim_id_q    <= '0;
            irq_q         <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_INT; i++) begin
                state_q[i] <= state_d[i];
            end
            latch_q       <= latch_d;
            claim_valid_q <= claim_req;
            claim_id_q    <= claim_req ? sel_id : '0;
            irq_q         <= |(pend_vec & int_enable);
            err_q         <= complete_err;
        end
    end

    always_comb begin
        dbg_line_state = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            dbg_line_state[2*i +: 2] = state_q[i];
        end
    end

    assign claim_valid  = claim_valid_q;
    assign claim_id     = claim_id_q;
    assign irq_out      = irq_q;
    assign pending_out  = pend_vec;
    assign err_complete = err_q;

endmodule

// File: tb/tb_global_int_gateway.sv
// Directed bench for global_int_gateway: reset, level/edge lines, priority,
// enable gating and illegal completions, with hand-computed expectations.
module tb_global_int_gateway;

    localparam int NUM_INT = 64;
    localparam int ID_W    = 7;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NUM_INT-1:0]   int_in;
    logic [NUM_INT-1:0]   int_edge_mode;
    logic [NUM_INT-1:0]   int_enable;
    logic                 claim_req;
    logic                 claim_valid;
    logic [ID_W-1:0]      claim_id;
    logic                 complete_valid;
    logic [ID_W-1:0]      complete_id;
    logic                 irq_out;
    logic [NUM_INT-1:0]   pending_out;
    logic                 err_complete;
    logic [2*NUM_INT-1:0] dbg_line_state;

    int n_cmp = 0;
    int n_err = 0;

    global_int_gateway #(.NUM_INT(NUM_INT), .ID_W(ID_W), .SYNC_STAGES(2)) dut (
        .clock         (clock),
        .reset         (reset),
        .int_in        (int_in),
        .int_edge_mode (int_edge_mode),
        .int_enable    (int_enable),
        .claim_req     (claim_req),
        .claim_valid   (claim_valid),
        .claim_id      (claim_id),
        .complete_valid(complete_valid),
        .complete_id   (complete_id),
        .irq_out       (irq_out),
        .pending_out   (pending_out),
        .err_complete  (err_complete),
        .dbg_line_state(dbg_line_state)
    );

    always #5 clock = ~clock;

    // Advance n rising edges; inputs are driven and outputs sampled 1ns later.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        step(3);
        n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", irq_out); end
        n_cmp++; if (pending_out !== 64'h0) begin n_err++; $display("FAIL reset_pending got=%h exp=0", pending_out); end
        n_cmp++; if (claim_valid !== 1'b0) begin n_err++; $display("FAIL reset_claim_valid got=%b exp=0", claim_valid); end
        n_cmp++; if (err_complete !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", err_complete); end
        n_cmp++; if (dbg_line_state !== '0) begin n_err++; $display("FAIL reset_state got=%h exp=0", dbg_line_state); end
        reset = 1'b1;
        step(1);
        n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL release_irq_early got=%b exp=0", irq_out); end
        n_cmp++; if (pending_out !== 64'h0) begin n_err++; $display("FAIL release_pending_early got=%h exp=0", pending_out); end
        step(3);
        n_cmp++; if (irq_out !== 1'b1) begin n_err++; $display("FAIL release_irq got=%b exp=1", irq_out); end
        n_cmp++; if (pending_out !== {NUM_INT{1'b1}}) begin n_err++; $display("FAIL release_pending got=%h exp=all ones", pending_out); end
        // Reset mid-operation discards everything.
        int_in = '0;
        reset  = 1'b0;
        step(2);
        n_cmp++; if (pending_out !== 64'h0) begin n_err++; $display("FAIL midreset_pending got=%h exp=0", pending_out); end
        n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL midreset_irq got=%b exp=0", irq_out); end
        reset = 1'b1;
        step(2);
    endtask

    task automatic test_level;
        int_in[5] = 1'b1;
        step(4);
        int_in[5] = 1'b0;
        n_cmp++; if (pending_out !== 64'h20) begin n_err++; $display("FAIL level_pending got=%h exp=20", pending_out); end
        n_cmp++; if (irq_out !== 1'b1) begin n_err++; $display("FAIL level_irq got=%b exp=1", irq_out); end
        claim_req = 1'b1;
        step(1);
        claim_req = 1'b0;
        n_cmp++; if (claim_valid !== 1'b1) begin n_err++; $display("FAIL level_claim_valid got=%b exp=1", claim_valid); end
        n_cmp++; if (claim_id !== 7'd6) begin n_err++; $display("FAIL level_claim_id got=%0d exp=6", claim_id); end
        n_cmp++; if (pending_out !== 64'h0) begin n_err++; $display("FAIL level_inflight_pending got=%h exp=0", pending_out); end
        step(1);
        n_cmp++; if (claim_valid !== 1'b0) begin n_err++; $display("FAIL level_claim_pulse got=%b exp=0", claim_valid); end
        step(2);
        complete_valid = 1'b1;
        complete_id    = 7'd6;
        step(1);
        complete_valid = 1'b0;
        n_cmp++; if (err_complete !== 1'b0) begin n_err++; $display("FAIL level_complete_err got=%b exp=0", err_complete); end
        step(1);
        n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL level_done_irq got=%b exp=0", irq_out); end
        n_cmp++; if (pending_out !== 64'h0) begin n_err++; $display("FAIL level_done_pending got=%h exp=0", pending_out); end
    endtask

    task automatic test_priority;
        int_in[3]  = 1'b1;
        int_in[10] = 1'b1;
        step(3);
        int_in[3]  = 1'b0;
        int_in[10] = 1'b0;
        step(4);
        // Level lines stay pending after their input drops.
        n_cmp++; if (pending_out !== 64'h408) begin n_err++; $display("FAIL prio_pending got=%h exp=408", pending_out); end
        claim_req = 1'b1;
        step(1);
        n_cmp++; if (claim_id !== 7'd4) begin n_err++; $display("FAIL prio_first_id got=%0d exp=4", claim_id); end
        step(1);
        n_cmp++; if (claim_id !== 7'd11) begin n_err++; $display("FAIL prio_second_id got=%0d exp=11", claim_id); end
        step(1);
        claim_req = 1'b0;
        n_cmp++; if (claim_valid !== 1'b1) begin n_err++; $display("FAIL prio_third_valid got=%b exp=1", claim_valid); end
        n_cmp++; if (claim_id !== 7'd0) begin n_err++; $display("FAIL prio_third_id got=%0d exp=0", claim_id); end
        step(1);
        n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL prio_irq got=%b exp=0", irq_out); end
        complete_valid = 1'b1;
        complete_id    = 7'd4;
        step(1);
        n_cmp++; if (err_complete !== 1'b0) begin n_err++; $display("FAIL prio_complete4_err got=%b exp=0", err_complete); end
        complete_id = 7'd11;
        step(1);
        complete_valid = 1'b0;
        n_cmp++; if (err_complete !== 1'b0) begin n_err++; $display("FAIL prio_complete11_err got=%b exp=0", err_complete); end
        step(1);
        n_cmp++; if (dbg_line_state !== '0) begin n_err++; $display("FAIL prio_idle_state got=%h exp=0", dbg_line_state); end
    endtask

    task automatic test_edge_latch;
        int_edge_mode[0] = 1'b1;
        int_in[0] = 1'b1;
        step(4);
        n_cmp++; if (pending_out !== 64'h1) begin n_err++; $display("FAIL edge_pending got=%h exp=1", pending_out); end
        claim_req = 1'b1;
        step(1);
        claim_req = 1'b0;
        n_cmp++; if (claim_id !== 7'd1) begin n_err++; $display("FAIL edge_claim_id got=%0d exp=1", claim_id); end
        for (int k = 0; k < 2; k++) begin
            int_in[0] = 1'b0;
            step(3);
            int_in[0] = 1'b1;
            step(3);
        end
        int_in[0] = 1'b0;
        step(3);
        n_cmp++; if (pending_out !== 64'h0) begin n_err++; $display("FAIL edge_inflight_pending got=%h exp=0", pending_out); end
        complete_valid = 1'b1;
        complete_id    = 7'd1;
        step(1);
        complete_valid = 1'b0;
        n_cmp++; if (pending_out !== 64'h1) begin n_err++; $display("FAIL edge_repending got=%h exp=1", pending_out); end
        step(3);
        n_cmp++; if (pending_out !== 64'h1) begin n_err++; $display("FAIL edge_hold_pending got=%h exp=1", pending_out); end
        claim_req = 1'b1;
        step(1);
        claim_req = 1'b0;
        n_cmp++; if (claim_id !== 7'd1) begin n_err++; $display("FAIL edge_reclaim_id got=%0d exp=1", claim_id); end
        complete_valid = 1'b1;
        complete_id    = 7'd1;
        step(1);
        complete_valid = 1'b0;
        step(2);
        n_cmp++; if (pending_out !== 64'h0) begin n_err++; $display("FAIL edge_idle_pending got=%h exp=0", pending_out); end
        n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL edge_idle_irq got=%b exp=0", irq_out); end
        int_edge_mode[0] = 1'b0;
    endtask

    task automatic test_enable_gating;
        int_enable[7] = 1'b0;
        int_in[7] = 1'b1;
        step(4);
        int_in[7] = 1'b0;
        step(2);
        n_cmp++; if (pending_out !== 64'h80) begin n_err++; $display("FAIL gate_pending got=%h exp=80", pending_out); end
        n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL gate_irq got=%b exp=0", irq_out); end
        claim_req = 1'b1;
        step(1);
        claim_req = 1'b0;
        n_cmp++; if (claim_id !== 7'd0) begin n_err++; $display("FAIL gate_claim_id got=%0d exp=0", claim_id); end
        n_cmp++; if (pending_out !== 64'h80) begin n_err++; $display("FAIL gate_still_pending got=%h exp=80", pending_out); end
        int_enable[7] = 1'b1;
        step(1);
        n_cmp++; if (irq_out !== 1'b1) begin n_err++; $display("FAIL gate_reenable_irq got=%b exp=1", irq_out); end
        claim_req = 1'b1;
        step(1);
        claim_req = 1'b0;
        n_cmp++; if (claim_id !== 7'd8) begin n_err++; $display("FAIL gate_claim8 got=%0d exp=8", claim_id); end
        complete_valid = 1'b1;
        complete_id    = 7'd8;
        step(1);
        complete_valid = 1'b0;
        n_cmp++; if (err_complete !== 1'b0) begin n_err++; $display("FAIL gate_complete_err got=%b exp=0", err_complete); end
    endtask

    task automatic test_illegal_complete;
        logic [ID_W-1:0] bad_ids [4];
        bad_ids[0] = 7'd0;
        bad_ids[1] = 7'd65;
        bad_ids[2] = 7'd3;
        bad_ids[3] = 7'd7;
        int_in[2] = 1'b1;
        step(3);
        int_in[2] = 1'b0;
        step(3);
        for (int k = 0; k < 4; k++) begin
            complete_valid = 1'b1;
            complete_id    = bad_ids[k];
            step(1);
            complete_valid = 1'b0;
            n_cmp++; if (err_complete !== 1'b1) begin n_err++; $display("FAIL illegal_err id=%0d got=%b exp=1", bad_ids[k], err_complete); end
            n_cmp++; if (pending_out !== 64'h4) begin n_err++; $display("FAIL illegal_pending id=%0d got=%h exp=4", bad_ids[k], pending_out); end
            step(1);
            n_cmp++; if (err_complete !== 1'b0) begin n_err++; $display("FAIL illegal_pulse id=%0d got=%b exp=0", bad_ids[k], err_complete); end
        end
    endtask

    task automatic test_back_to_back;
        // Line 2 is pending from the previous test; claim it, then complete it
        // in the same cycle as a claim that must find nothing.
        claim_req = 1'b1;
        step(1);
        n_cmp++; if (claim_id !== 7'd3) begin n_err++; $display("FAIL b2b_claim_id got=%0d exp=3", claim_id); end
        int_in[2] = 1'b1;
        step(1);
        n_cmp++; if (claim_id !== 7'd0) begin n_err++; $display("FAIL b2b_empty_id got=%0d exp=0", claim_id); end
        claim_req = 1'b0;
        step(2);
        // Level input is high again, so completion re-triggers the line.
        claim_req      = 1'b1;
        complete_valid = 1'b1;
        complete_id    = 7'd3;
        step(1);
        claim_req      = 1'b0;
        complete_valid = 1'b0;
        n_cmp++; if (claim_id !== 7'd0) begin n_err++; $display("FAIL b2b_same_cycle_id got=%0d exp=0", claim_id); end
        n_cmp++; if (err_complete !== 1'b0) begin n_err++; $display("FAIL b2b_complete_err got=%b exp=0", err_complete); end
        int_in[2] = 1'b0;
        step(1);
        n_cmp++; if (pending_out !== 64'h4) begin n_err++; $display("FAIL b2b_retrigger got=%h exp=4", pending_out); end
    endtask

    initial begin
        reset          = 1'b0;
        int_in         = {NUM_INT{1'b1}};
        int_edge_mode  = '0;
        int_enable     = {NUM_INT{1'b1}};
        claim_req      = 1'b0;
        complete_valid = 1'b0;
        complete_id    = '0;
        test_reset();
        test_level();
        test_priority();
        test_edge_latch();
        test_enable_gating();
        test_illegal_complete();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
